// File: rtl/segment_transition_ctl_if.sv
// Request/status bundle between the controller register file, index generator and
// segment_transition_ctl. master = controller side, slave = sequencer.
interface segment_transition_ctl_if #(
    parameter int NUM_SEGMENT = 4,
    parameter int SEG_W       = $clog2(NUM_SEGMENT),
    parameter int REP_W       = 16,
    parameter int NUM_GPIO    = 4
);
    logic                         UPDATE;
    logic [SEG_W-1:0]             REQ_SEGMENT;
    logic [7:0]                   TRANSITION_MODE;
    logic [63:0]                  TRANSITION_VALUE;
    logic [NUM_SEGMENT*REP_W-1:0] REP;
    logic                         IDX_WRAP;
    logic [63:0]                  SYS_TIME;
    logic [NUM_GPIO-1:0]          GPIO_IN;
    logic [SEG_W-1:0]             SEGMENT;
    logic                         SEG_CHANGE;
    logic                         STOP;
    logic                         BUSY;
    logic                         ERR;
    logic [REP_W-1:0]             LOOP_CNT;

    modport master (
        output UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE, REP,
               IDX_WRAP, SYS_TIME, GPIO_IN,
        input  SEGMENT, SEG_CHANGE, STOP, BUSY, ERR, LOOP_CNT
    );

    modport slave (
        input  UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE, REP,
               IDX_WRAP, SYS_TIME, GPIO_IN,
        output SEGMENT, SEG_CHANGE, STOP, BUSY, ERR, LOOP_CNT
    );
endinterface

// File: rtl/segment_transition_ctl.sv
// Per-stream N-segment sequencer: pending switch request, transition triggers, loop counting,
// auto-advance and finite-repetition stop. GPIO trigger built only with SEGMENT_TRANSITION_GPIO_EN.
module segment_transition_ctl #(
    parameter int NUM_SEGMENT = 4,
    parameter int SEG_W       = $clog2(NUM_SEGMENT),
    parameter int REP_W       = 16,
    parameter int NUM_GPIO    = 4
) (
    input logic                    CLK,
    input logic                    RESET_N,
    segment_transition_ctl_if.slave bus
);
    localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] MODE_GPIO      = 8'h02;
    localparam logic [7:0] MODE_EXT       = 8'hF0;
    localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_STOPPED} state_t;

    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic [7:0]       mode;
        logic [63:0]      val;
    } pend_req_t;

    state_t           state, state_nxt;
    pend_req_t        pend;
    logic [SEG_W-1:0] segment, seg_inc;
    logic             seg_change, stop, err, auto_adv, busy;
    logic [REP_W-1:0] loop_cnt, cnt_inc, rep_cur;
    logic [63:0]      sys_time_q;
    logic             mode_ok, seg_ok, upd_ok, upd_bad;
    logic             trig_cond, take, wrap_cnt, exhaust, adv;
    logic             gpio_hit;

    // Request validation
    always_comb begin
        mode_ok = 1'b0;
        case (bus.TRANSITION_MODE)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_EXT, MODE_IMMEDIATE: mode_ok = 1'b1;
`ifdef SEGMENT_TRANSITION_GPIO_EN
            MODE_GPIO: mode_ok = 1'b1;
`endif
            default: mode_ok = 1'b0;
        endcase
    end

    assign seg_ok  = {1'b0, bus.REQ_SEGMENT} < (SEG_W+1)'(NUM_SEGMENT);
    assign upd_ok  = bus.UPDATE && mode_ok && seg_ok;
    assign upd_bad = bus.UPDATE && !upd_ok;

`ifdef SEGMENT_TRANSITION_GPIO_EN
    logic [NUM_GPIO-1:0] gpio_s1, gpio_s2, gpio_s3, gpio_rise;

    // 2-flop synchroniser, history flop, registered rising edge
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            gpio_s1   <= '0;
            gpio_s2   <= '0;
            gpio_s3   <= '0;
            gpio_rise <= '0;
        end else begin
            gpio_s1   <= bus.GPIO_IN;
            gpio_s2   <= gpio_s1;
            gpio_s3   <= gpio_s2;
            gpio_rise <= gpio_s2 & ~gpio_s3;
        end
    end

    always_comb begin
        gpio_hit = 1'b0;
        for (int i = 0; i < NUM_GPIO; i++)
            if (i < 4 && pend.val[1:0] == 2'(i)) gpio_hit = gpio_rise[i];
    end
`else
    logic gpio_unused;
    assign gpio_unused = ^bus.GPIO_IN;
    assign gpio_hit    = 1'b0;
`endif

    always_comb begin
        trig_cond = 1'b0;
        case (pend.mode)
            MODE_SYNC_IDX:            trig_cond = bus.IDX_WRAP;
            MODE_SYS_TIME:            trig_cond = sys_time_q >= pend.val;
            MODE_GPIO:                trig_cond = gpio_hit;
            MODE_EXT, MODE_IMMEDIATE: trig_cond = 1'b1;
            default:                  trig_cond = 1'b0;
        endcase
    end

    always_comb begin
        rep_cur = '0;
        for (int k = 0; k < NUM_SEGMENT; k++)
            if (segment == SEG_W'(k)) rep_cur = bus.REP[k*REP_W +: REP_W];
    end

    // A fresh UPDATE always beats a trigger of the older pending request
    assign take     = (state == ST_PEND) && trig_cond && !upd_ok;
    assign cnt_inc  = (&loop_cnt) ? loop_cnt : loop_cnt + 1'b1;
    assign wrap_cnt = bus.IDX_WRAP && (state != ST_STOPPED);
    assign exhaust  = wrap_cnt && !(&rep_cur) && (cnt_inc == rep_cur + 1'b1);
    assign adv      = exhaust && auto_adv && (state == ST_RUN);
    assign seg_inc  = (segment == SEG_W'(NUM_SEGMENT-1)) ? '0 : segment + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (upd_ok)
            state_nxt = ST_PEND;
        else if (take)
            state_nxt = ST_RUN;
        else if (state == ST_RUN && exhaust && !auto_adv)
            state_nxt = ST_STOPPED;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pend       <= '0;
            segment    <= '0;
            seg_change <= 1'b0;
            stop       <= 1'b0;
            err        <= 1'b0;
            auto_adv   <= 1'b0;
            loop_cnt   <= '0;
            sys_time_q <= '0;
        end else begin
            sys_time_q <= bus.SYS_TIME;
            seg_change <= 1'b0;
            err        <= upd_bad;
            if (upd_ok)
                pend <= '{seg: bus.REQ_SEGMENT, mode: bus.TRANSITION_MODE, val: bus.TRANSITION_VALUE};
            if (take) begin
                segment    <= pend.seg;
                loop_cnt   <= '0;
                stop       <= 1'b0;
                seg_change <= 1'b1;
                auto_adv   <= (pend.mode == MODE_EXT);
            end else if (wrap_cnt) begin
                if (adv) begin
                    segment    <= seg_inc;
                    loop_cnt   <= '0;
                    seg_change <= 1'b1;
                end else begin
                    loop_cnt <= cnt_inc;
                    // in PEND an exhausted count only flags STOP; the pending switch clears it
                    if (exhaust) stop <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy           = (state == ST_PEND);
        bus.BUSY       = busy;
        bus.SEGMENT    = segment;
        bus.SEG_CHANGE = seg_change;
        bus.STOP       = stop;
        bus.ERR        = err;
        bus.LOOP_CNT   = loop_cnt;
    end
endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: a one-cycle vector table plus hand sequences
// for wrap timing, SYS_TIME ramp, finite stop, EXT round robin, GPIO and reset in PEND.
module tb_segment_transition_ctl;
    localparam int NS = 4, SW = 3, RW = 16, NG = 4;
    localparam logic [7:0] M_SYNC = 8'h00, M_SYS = 8'h01, M_GPIO = 8'h02, M_EXT = 8'hF0, M_IMM = 8'hFF;

    logic CLK = 1'b0;
    logic RESET_N;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    segment_transition_ctl_if #(.NUM_SEGMENT(NS), .SEG_W(SW), .REP_W(RW), .NUM_GPIO(NG)) bus ();

    segment_transition_ctl #(.NUM_SEGMENT(NS), .SEG_W(SW), .REP_W(RW), .NUM_GPIO(NG)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic        upd;
        logic [2:0]  seg;
        logic [7:0]  mode;
        logic        wrap;
        logic [2:0]  e_seg;
        logic        e_chg, e_stop, e_busy, e_err;
        logic [15:0] e_loop;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic upd, logic [2:0] seg, logic [7:0] mode, logic wrap,
                                logic [2:0] e_seg, logic e_chg, logic e_stop, logic e_busy,
                                logic e_err, logic [15:0] e_loop);
        vec_t v;
        v.upd = upd; v.seg = seg; v.mode = mode; v.wrap = wrap;
        v.e_seg = e_seg; v.e_chg = e_chg; v.e_stop = e_stop; v.e_busy = e_busy;
        v.e_err = e_err; v.e_loop = e_loop;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [2:0] seg, logic chg, logic stop, logic busy,
                           logic err, logic [15:0] loop_cnt);
        chk({tag, ".SEGMENT"},    64'(bus.SEGMENT),    64'(seg));
        chk({tag, ".SEG_CHANGE"}, 64'(bus.SEG_CHANGE), 64'(chg));
        chk({tag, ".STOP"},       64'(bus.STOP),       64'(stop));
        chk({tag, ".BUSY"},       64'(bus.BUSY),       64'(busy));
        chk({tag, ".ERR"},        64'(bus.ERR),        64'(err));
        chk({tag, ".LOOP_CNT"},   64'(bus.LOOP_CNT),   64'(loop_cnt));
    endtask

    task automatic req(logic [2:0] seg, logic [7:0] mode, logic [63:0] val);
        bus.UPDATE = 1'b1; bus.REQ_SEGMENT = seg; bus.TRANSITION_MODE = mode; bus.TRANSITION_VALUE = val;
        tick();
        bus.UPDATE = 1'b0;
    endtask

    task automatic wrap();
        bus.IDX_WRAP = 1'b1;
        tick();
        bus.IDX_WRAP = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_seg;

        // upd seg mode wrap | seg chg stop busy err loop
        vecs[0]  = mk(1, 3'd2, M_IMM,  0, 3'd0, 0, 0, 1, 0, 16'd0);
        vecs[1]  = mk(0, 3'd0, M_IMM,  0, 3'd2, 1, 0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 3'd0, M_IMM,  0, 3'd2, 0, 0, 0, 0, 16'd0);
        vecs[3]  = mk(0, 3'd0, M_IMM,  1, 3'd2, 0, 0, 0, 0, 16'd1);
        vecs[4]  = mk(0, 3'd0, M_IMM,  1, 3'd2, 0, 0, 0, 0, 16'd2);
        vecs[5]  = mk(1, 3'd1, M_SYNC, 0, 3'd2, 0, 0, 1, 0, 16'd2);
        vecs[6]  = mk(0, 3'd0, M_IMM,  0, 3'd2, 0, 0, 1, 0, 16'd2);
        vecs[7]  = mk(0, 3'd0, M_IMM,  1, 3'd1, 1, 0, 0, 0, 16'd0);
        vecs[8]  = mk(1, 3'd5, M_IMM,  0, 3'd1, 0, 0, 0, 1, 16'd0);
        vecs[9]  = mk(1, 3'd0, 8'h33,  0, 3'd1, 0, 0, 0, 1, 16'd0);
        vecs[10] = mk(0, 3'd0, M_IMM,  1, 3'd1, 0, 0, 0, 0, 16'd1);
        vecs[11] = mk(1, 3'd1, M_IMM,  0, 3'd1, 0, 0, 1, 0, 16'd1);
        vecs[12] = mk(0, 3'd0, M_IMM,  0, 3'd1, 1, 0, 0, 0, 16'd0);
        vecs[13] = mk(1, 3'd3, M_SYNC, 0, 3'd1, 0, 0, 1, 0, 16'd0);
        vecs[14] = mk(1, 3'd0, M_IMM,  1, 3'd1, 0, 0, 1, 0, 16'd1);
        vecs[15] = mk(0, 3'd0, M_IMM,  0, 3'd0, 1, 0, 0, 0, 16'd0);

        // reset with a valid IMMEDIATE request held: reset must dominate
        RESET_N = 1'b0;
        bus.UPDATE = 1'b1; bus.REQ_SEGMENT = 3'd2; bus.TRANSITION_MODE = M_IMM;
        bus.TRANSITION_VALUE = '0; bus.REP = '1; bus.IDX_WRAP = 1'b0;
        bus.SYS_TIME = '0; bus.GPIO_IN = '0;
        tick(); tick();
        chk_all("reset", 3'd0, 0, 0, 0, 0, 16'd0);
        bus.UPDATE = 1'b0;
        RESET_N = 1'b1;
        tick();
        chk_all("post_reset", 3'd0, 0, 0, 0, 0, 16'd0);

        for (int i = 0; i < 16; i++) begin
            bus.UPDATE = vecs[i].upd; bus.REQ_SEGMENT = vecs[i].seg;
            bus.TRANSITION_MODE = vecs[i].mode; bus.TRANSITION_VALUE = '0;
            bus.IDX_WRAP = vecs[i].wrap;
            tick();
            bus.UPDATE = 1'b0; bus.IDX_WRAP = 1'b0;
            chk_all($sformatf("vec%0d", i), vecs[i].e_seg, vecs[i].e_chg, vecs[i].e_stop,
                    vecs[i].e_busy, vecs[i].e_err, vecs[i].e_loop);
        end

        // SYNC_IDX held 30 cycles, switch on the cycle after the wrap
        req(3'd1, M_SYNC, '0);
        chk("sync30.busy0", 64'(bus.BUSY), 64'd1);
        for (int i = 1; i < 30; i++) begin
            tick();
            chk($sformatf("sync30.busy%0d", i), 64'(bus.BUSY), 64'd1);
        end
        wrap();
        chk_all("sync30.switch", 3'd1, 1, 0, 0, 0, 16'd0);

        // SYS_TIME ramp 990.. towards a target of 1000
        bus.SYS_TIME = 64'd989;
        req(3'd2, M_SYS, 64'd1000);
        chk("sys.busy", 64'(bus.BUSY), 64'd1);
        for (int i = 0; i <= 11; i++) begin
            bus.SYS_TIME = 64'(990 + i);
            tick();
            if (i < 11) begin
                chk($sformatf("sys.hold%0d", i), 64'(bus.SEGMENT), 64'd1);
                chk($sformatf("sys.chg%0d", i), 64'(bus.SEG_CHANGE), 64'd0);
            end else begin
                chk_all("sys.switch", 3'd2, 1, 0, 0, 0, 16'd0);
            end
        end
        bus.SYS_TIME = 64'd1000;
        req(3'd3, M_SYS, 64'd5);
        chk_all("sys_past.pend", 3'd2, 0, 0, 1, 0, 16'd0);
        tick();
        chk_all("sys_past.switch", 3'd3, 1, 0, 0, 0, 16'd0);

        // finite repetition: REP[0]=2 stops after 3 wraps
        bus.REP = {16'd1, 16'd1, 16'd1, 16'd2};
        req(3'd0, M_IMM, '0);
        tick();
        chk_all("fin.switch", 3'd0, 1, 0, 0, 0, 16'd0);
        wrap(); chk_all("fin.w1", 3'd0, 0, 0, 0, 0, 16'd1);
        wrap(); chk_all("fin.w2", 3'd0, 0, 0, 0, 0, 16'd2);
        wrap(); chk_all("fin.w3", 3'd0, 0, 1, 0, 0, 16'd3);
        wrap(); chk_all("fin.w4", 3'd0, 0, 1, 0, 0, 16'd3);

        // EXT from segment 3, REP=1 everywhere: 3,0,1,2,3 every 2 wraps
        bus.REP = {16'd1, 16'd1, 16'd1, 16'd1};
        req(3'd3, M_EXT, '0);
        chk_all("ext.pend", 3'd0, 0, 1, 1, 0, 16'd3);
        tick();
        chk_all("ext.switch", 3'd3, 1, 0, 0, 0, 16'd0);
        exp_seg = 3'd3;
        for (int k = 0; k < 4; k++) begin
            wrap();
            chk_all($sformatf("ext.a%0d", k), exp_seg, 0, 0, 0, 0, 16'd1);
            exp_seg = (exp_seg == 3'd3) ? 3'd0 : exp_seg + 3'd1;
            wrap();
            chk_all($sformatf("ext.b%0d", k), exp_seg, 1, 0, 0, 0, 16'd0);
        end

`ifdef SEGMENT_TRANSITION_GPIO_EN
        req(3'd1, M_GPIO, 64'd2);
        chk_all("gpio.pend", 3'd3, 0, 0, 1, 0, 16'd0);
        bus.GPIO_IN = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_all($sformatf("gpio.wait%0d", i), 3'd3, 0, 0, 1, 0, 16'd0);
        end
        tick();
        chk_all("gpio.switch", 3'd1, 1, 0, 0, 0, 16'd0);
        bus.GPIO_IN = '0;
`else
        req(3'd1, M_GPIO, 64'd2);
        chk_all("gpio_off.err", 3'd3, 0, 0, 0, 1, 16'd0);
        tick();
        chk_all("gpio_off.after", 3'd3, 0, 0, 0, 0, 16'd0);
`endif

        // reset while pending discards the request and auto-advance
        req(3'd2, M_SYNC, '0);
        chk("rstpend.busy", 64'(bus.BUSY), 64'd1);
        RESET_N = 1'b0;
        bus.UPDATE = 1'b1; bus.REQ_SEGMENT = 3'd1; bus.TRANSITION_MODE = M_IMM;
        tick();
        chk_all("rstpend.reset", 3'd0, 0, 0, 0, 0, 16'd0);
        RESET_N = 1'b1;
        bus.UPDATE = 1'b0;
        wrap(); chk_all("rstpend.w1", 3'd0, 0, 0, 0, 0, 16'd1);
        wrap(); chk_all("rstpend.w2", 3'd0, 0, 1, 0, 0, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
